// File: rtl/weight_stream_fetcher_if.sv
// weight_stream_fetcher_if: job control, batched ROM port and one-weight-per-beat stream
interface weight_stream_fetcher_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int BATCH_SIZE = 8
);
  logic                             start;
  logic [ADDR_WIDTH-1:0]            base_addr;
  logic [ADDR_WIDTH:0]              num_weights;
  logic [ADDR_WIDTH-1:0]            rom_addr;
  logic [DATA_WIDTH*BATCH_SIZE-1:0] rom_data;
  logic [DATA_WIDTH-1:0]            w_data;
  logic                             w_valid;
  logic                             w_ready;
  logic                             w_last;
  logic                             busy;
  logic                             done;
  modport master (
    input  start, base_addr, num_weights, rom_data, w_ready,
    output rom_addr, w_data, w_valid, w_last, busy, done
  );
  modport slave (
    output start, base_addr, num_weights, rom_data, w_ready,
    input  rom_addr, w_data, w_valid, w_last, busy, done
  );
endinterface

// File: rtl/weight_stream_fetcher.sv
// weight_stream_fetcher: walks a weight region in ROM batches and serialises them into a beat stream
module weight_stream_fetcher #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int BATCH_SIZE = 8,
  parameter int FIFO_DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  weight_stream_fetcher_if.master bus
);
  localparam int BW = DATA_WIDTH * BATCH_SIZE;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BI = $clog2(BATCH_SIZE);
  localparam int CW = ADDR_WIDTH + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] n_q, total_q, issued_q, beats_q;
  logic [BI-1:0] idx_q;
  logic inflight_q;
  logic [BW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0] cnt_q;
  logic [ADDR_WIDTH-1:0] rom_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q, head_byte;
  logic w_valid_q, w_last_q;
  logic go, issue, adv, load, pop, last_acc, final_beat;
  always_comb begin
    go = bus.start && state == IDLE;
    issue = state == RUN && issued_q < total_q &&
            (PW+2)'(cnt_q) + (PW+2)'(inflight_q) < (PW+2)'(FIFO_DEPTH);
    adv = !w_valid_q || bus.w_ready;
    final_beat = beats_q + CW'(1) == n_q;
    load = state == RUN && adv && cnt_q != '0 && beats_q < n_q;
    pop = load && (idx_q == BI'(BATCH_SIZE - 1) || final_beat);
    head_byte = mem[rd_q][idx_q*DATA_WIDTH +: DATA_WIDTH];
    last_acc = w_valid_q && bus.w_ready && w_last_q;
    state_nxt = state == IDLE ? (go ? (bus.num_weights == '0 ? DONE : RUN) : IDLE) :
                state == RUN  ? (last_acc ? DONE : RUN) : IDLE;
    bus.busy = state != IDLE;
    bus.done = state == DONE;
    bus.rom_addr = rom_addr_q;
    bus.w_data = w_data_q;
    bus.w_valid = w_valid_q;
    bus.w_last = w_last_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // FIFO storage needs no reset: occupancy is tracked by cnt_q
  always_ff @(posedge clk)
    if (inflight_q) mem[wr_q] <= bus.rom_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= '0;
      total_q <= '0;
      issued_q <= '0;
      beats_q <= '0;
      idx_q <= '0;
      inflight_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      rom_addr_q <= '0;
      w_data_q <= '0;
      w_valid_q <= 1'b0;
      w_last_q <= 1'b0;
    end else begin
      if (go) begin
        n_q <= bus.num_weights;
        total_q <= CW'((bus.num_weights + CW'(BATCH_SIZE - 1)) >> BI);
        issued_q <= '0;
        beats_q <= '0;
        idx_q <= '0;
        if (bus.num_weights != '0) rom_addr_q <= bus.base_addr;
      end
      // Advance the address only if another read follows, so it holds the last one afterwards
      if (issue) begin
        issued_q <= issued_q + CW'(1);
        if (issued_q + CW'(1) < total_q) rom_addr_q <= rom_addr_q + ADDR_WIDTH'(BATCH_SIZE);
      end
      inflight_q <= issue;
      if (inflight_q) wr_q <= wr_q + PW'(1);
      if (pop) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(inflight_q) - (PW+1)'(pop);
      if (load) begin
        w_data_q <= head_byte;
        w_last_q <= final_beat;
        beats_q <= beats_q + CW'(1);
        idx_q <= pop ? '0 : idx_q + BI'(1);
      end
      if (adv) w_valid_q <= load;
    end
  end
endmodule

// File: tb/tb_weight_stream_fetcher.sv
// tb_weight_stream_fetcher: directed job table plus zero-length, ignored-start and mid-job reset sequences
module tb_weight_stream_fetcher;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [63:0] rom_nxt;
  weight_stream_fetcher_if bus ();
  weight_stream_fetcher dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction
  always_comb begin
    rom_nxt = '0;
    for (int i = 0; i < 8; i++) rom_nxt[i*8 +: 8] = rom_byte(bus.rom_addr + 16'(i));
  end
  always @(posedge clk) bus.rom_data <= rom_nxt;
  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  typedef struct {
    logic [15:0] base;
    logic [16:0] n;
    int          duty;
    bit          poke;
    int          exp_reads;
    logic [15:0] exp_last;
  } vec_t;
  vec_t vecs[7];
  task automatic run_job(input vec_t v);
    int beats = 0;
    int cyc = 0;
    int last_cyc = -1;
    int done_cyc = -1;
    bit stalled = 1'b0;
    logic [7:0] sd = '0;
    logic sl = 1'b0;
    logic [7:0] last_data = '0;
    logic [15:0] prev;
    logic [15:0] addrs[$];
    bus.base_addr = v.base;
    bus.num_weights = v.n;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    prev = bus.rom_addr;
    addrs.push_back(prev);
    chk(bus.busy == 1'b1, "busy_rise", 32'(bus.busy), 32'd1);
    while (done_cyc < 0 && cyc < 3000) begin
      if (bus.rom_addr != prev) begin
        prev = bus.rom_addr;
        addrs.push_back(prev);
      end
      if (stalled)
        chk(bus.w_valid && bus.w_data == sd && bus.w_last == sl, "stall_hold",
            32'({bus.w_valid, bus.w_last, bus.w_data}), 32'({1'b1, sl, sd}));
      if (bus.done) begin
        done_cyc = cyc;
        chk(bus.busy == 1'b1, "busy_in_done", 32'(bus.busy), 32'd1);
        chk(bus.w_valid == 1'b0, "valid_in_done", 32'(bus.w_valid), 32'd0);
      end else begin
        bus.w_ready = $urandom_range(99) < 32'(v.duty);
        stalled = bus.w_valid && !bus.w_ready;
        sd = bus.w_data;
        sl = bus.w_last;
        if (bus.w_valid && bus.w_ready) begin
          chk(bus.w_data == rom_byte(v.base + beats[15:0]), "beat_data",
              32'(bus.w_data), 32'(rom_byte(v.base + beats[15:0])));
          chk(bus.w_last == (beats == int'(v.n) - 1), "beat_last", 32'(bus.w_last), 32'(beats == int'(v.n) - 1));
          if (bus.w_last) last_data = bus.w_data;
          beats++;
          last_cyc = cyc;
        end
        bus.start = v.poke && cyc == 10;
        if (v.poke && cyc == 10) begin
          bus.base_addr = 16'hAAAA;
          bus.num_weights = 17'd5;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk(done_cyc >= 0, "done_timeout", 32'(cyc), 32'd0);
    chk(done_cyc == last_cyc + 1, "done_latency", 32'(done_cyc), 32'(last_cyc + 1));
    chk(beats == int'(v.n), "beat_count", 32'(beats), 32'(v.n));
    chk(last_data == rom_byte(v.exp_last), "last_data", 32'(last_data), 32'(rom_byte(v.exp_last)));
    chk(addrs.size() == v.exp_reads, "read_count", 32'(addrs.size()), 32'(v.exp_reads));
    foreach (addrs[k])
      chk(addrs[k] == v.base + 16'(8 * k), "read_addr", 32'(addrs[k]), 32'(v.base + 16'(8 * k)));
    chk(!bus.busy && !bus.done, "busy_fall", 32'({bus.busy, bus.done}), 32'd0);
  endtask
  initial begin
    logic [15:0] held;
    int cnt;
    int cyc;
    vecs[0] = '{16'h0000, 17'd16, 100, 1'b0, 2, 16'h000F};
    vecs[1] = '{16'h0010, 17'd11, 100, 1'b0, 2, 16'h001A};
    vecs[2] = '{16'hFFF8, 17'd16, 100, 1'b0, 2, 16'h0007};
    vecs[3] = '{16'h0100, 17'd64,  30, 1'b0, 8, 16'h013F};
    vecs[4] = '{16'h0200, 17'd1,  100, 1'b0, 1, 16'h0200};
    vecs[5] = '{16'h0300, 17'd9,   50, 1'b0, 2, 16'h0308};
    vecs[6] = '{16'h0400, 17'd24, 100, 1'b1, 3, 16'h0417};
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.num_weights = '0;
    bus.w_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk({bus.rom_addr, bus.w_data, bus.w_valid, bus.w_last, bus.busy, bus.done} == '0, "reset_state",
        32'({bus.rom_addr, bus.w_data, bus.w_valid, bus.w_last, bus.busy, bus.done}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk(!bus.w_valid && !bus.busy, "idle_after_reset", 32'({bus.w_valid, bus.busy}), 32'd0);
    foreach (vecs[i]) run_job(vecs[i]);
    held = bus.rom_addr;
    bus.base_addr = 16'h1234;
    bus.num_weights = '0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk(bus.done && bus.busy, "zero_done", 32'({bus.done, bus.busy}), 32'd3);
    chk(bus.rom_addr == held, "zero_addr", 32'(bus.rom_addr), 32'(held));
    chk(!bus.w_valid, "zero_valid", 32'(bus.w_valid), 32'd0);
    @(negedge clk);
    chk(!bus.done && !bus.busy && !bus.w_valid, "zero_end", 32'({bus.done, bus.busy, bus.w_valid}), 32'd0);
    chk(bus.rom_addr == held, "zero_addr_hold", 32'(bus.rom_addr), 32'(held));
    bus.base_addr = 16'h0040;
    bus.num_weights = 17'd32;
    bus.w_ready = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    cyc = 0;
    while (cnt < 5 && cyc < 200) begin
      if (bus.w_valid && bus.w_ready) cnt++;
      @(negedge clk);
      cyc++;
    end
    chk(cnt == 5 && bus.busy, "rst_progress", 32'(cnt), 32'd5);
    rst_n = 1'b0;
    #1;
    chk({bus.rom_addr, bus.w_data, bus.w_valid, bus.w_last, bus.busy, bus.done} == '0, "midjob_reset",
        32'({bus.rom_addr, bus.w_data, bus.w_valid, bus.w_last, bus.busy, bus.done}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_job('{16'h0080, 17'd16, 100, 1'b0, 2, 16'h008F});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
